// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write port among NUM_PORTS engines; W follows AW grant order.
// Optional statistics counters (grant_cnt, fifo_full_cycles) when WR_ARB_STATS_EN is defined.
module axi_wr_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_WIDTH  = 33,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned ID_WIDTH    = 5,
  parameter int unsigned ORDER_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  // Per-engine slave side
  input  logic [NUM_PORTS-1:0]            s_axi_AWVALID,
  output logic [NUM_PORTS-1:0]            s_axi_AWREADY,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_axi_AWADDR,
  input  logic [NUM_PORTS*8-1:0]          s_axi_AWLEN,
  input  logic [NUM_PORTS-1:0]            s_axi_WVALID,
  input  logic [NUM_PORTS-1:0]            s_axi_WLAST,
  output logic [NUM_PORTS-1:0]            s_axi_WREADY,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axi_WDATA,
  output logic [NUM_PORTS-1:0]            s_axi_BVALID,
  output logic [NUM_PORTS*2-1:0]          s_axi_BRESP,
  input  logic [NUM_PORTS-1:0]            s_axi_BREADY,
  // Shared master side
  output logic                            m_axi_AWVALID,
  output logic [ADDR_WIDTH-1:0]           m_axi_AWADDR,
  output logic [7:0]                      m_axi_AWLEN,
  output logic [ID_WIDTH-1:0]             m_axi_AWID,
  input  logic                            m_axi_AWREADY,
  output logic                            m_axi_WVALID,
  output logic [DATA_WIDTH-1:0]           m_axi_WDATA,
  output logic                            m_axi_WLAST,
  input  logic                            m_axi_WREADY,
  input  logic                            m_axi_BVALID,
  input  logic [1:0]                      m_axi_BRESP,
  input  logic [ID_WIDTH-1:0]             m_axi_BID,
  output logic                            m_axi_BREADY
`ifdef WR_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]         grant_cnt,
  output logic [31:0]                     fifo_full_cycles
`endif
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned FW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam logic [PW-1:0] LastPort = PW'(NUM_PORTS - 1);

  logic                  aw_valid_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [PW-1:0]         rr_ptr_q;

  logic [PW-1:0]         fifo_mem [ORDER_DEPTH];
  logic [FW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [FW:0]           count_q;
  logic                  fifo_empty, fifo_full;

  logic                  aw_free, gnt, push, pop, w_en, bid_ok;
  logic [PW-1:0]         gnt_idx, head, bid_idx;
  int unsigned           cand;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (FW+1)'(ORDER_DEPTH));
  assign aw_free    = !aw_valid_q || m_axi_AWREADY;

  // Round-robin search starting at the port after the last grant.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (!rst && aw_free && !fifo_full) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cand = (32'(rr_ptr_q) + i) % NUM_PORTS;
        if (!gnt && s_axi_AWVALID[cand]) begin
          gnt     = 1'b1;
          gnt_idx = PW'(cand);
        end
      end
    end
  end

  always_comb begin
    s_axi_AWREADY = '0;
    if (gnt) s_axi_AWREADY[gnt_idx] = 1'b1;
  end

  assign push = gnt;
  assign pop  = m_axi_WVALID && m_axi_WREADY && m_axi_WLAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_id_q    <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (gnt) begin
        aw_valid_q <= 1'b1;
        aw_addr_q  <= s_axi_AWADDR[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        aw_len_q   <= s_axi_AWLEN[gnt_idx*8 +: 8];
        aw_id_q    <= ID_WIDTH'(gnt_idx);
        rr_ptr_q   <= (gnt_idx == LastPort) ? '0 : gnt_idx + 1'b1;
      end else if (m_axi_AWREADY) begin
        aw_valid_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= gnt_idx;
  end

  assign m_axi_AWVALID = aw_valid_q;
  assign m_axi_AWADDR  = aw_addr_q;
  assign m_axi_AWLEN   = aw_len_q;
  assign m_axi_AWID    = aw_id_q;

  // W follows the oldest outstanding AW; a port not at the head is stalled.
  assign head = fifo_mem[rd_ptr_q];
  assign w_en = !fifo_empty && !rst;

  always_comb begin
    m_axi_WVALID = w_en && s_axi_WVALID[head];
    m_axi_WLAST  = w_en && s_axi_WLAST[head];
    m_axi_WDATA  = s_axi_WDATA[head*DATA_WIDTH +: DATA_WIDTH];
    s_axi_WREADY = '0;
    if (w_en) s_axi_WREADY[head] = m_axi_WREADY;
  end

  // Responses carrying an ID outside the port range are acknowledged and dropped.
  assign bid_idx = m_axi_BID[PW-1:0];
  assign bid_ok  = ({1'b0, m_axi_BID} < (ID_WIDTH+1)'(NUM_PORTS));
  assign s_axi_BRESP = {NUM_PORTS{m_axi_BRESP}};

  always_comb begin
    s_axi_BVALID = '0;
    m_axi_BREADY = 1'b1;
    if (bid_ok) begin
      s_axi_BVALID[bid_idx] = m_axi_BVALID;
      m_axi_BREADY          = s_axi_BREADY[bid_idx];
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_PORTS];
  logic [31:0] full_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) grant_cnt_q[i] <= '0;
      full_cnt_q <= '0;
    end else begin
      if (gnt)       grant_cnt_q[gnt_idx] <= grant_cnt_q[gnt_idx] + 32'd1;
      if (fifo_full) full_cnt_q <= full_cnt_q + 32'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) grant_cnt[i*32 +: 32] = grant_cnt_q[i];
  end

  assign fifo_full_cycles = full_cnt_q;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: expected AW/W transfers queued at stimulus time,
// compared by a negedge monitor when the shared master port handshakes.
module tb_axi_wr_arbiter;
  localparam int NP = 4;
  localparam int AW = 33;
  localparam int DW = 256;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    s_axi_AWVALID, s_axi_AWREADY;
  logic [NP*AW-1:0] s_axi_AWADDR;
  logic [NP*8-1:0]  s_axi_AWLEN;
  logic [NP-1:0]    s_axi_WVALID, s_axi_WLAST, s_axi_WREADY;
  logic [NP*DW-1:0] s_axi_WDATA;
  logic [NP-1:0]    s_axi_BVALID, s_axi_BREADY;
  logic [NP*2-1:0]  s_axi_BRESP;
  logic             m_axi_AWVALID, m_axi_AWREADY;
  logic [AW-1:0]    m_axi_AWADDR;
  logic [7:0]       m_axi_AWLEN;
  logic [IW-1:0]    m_axi_AWID;
  logic             m_axi_WVALID, m_axi_WLAST, m_axi_WREADY;
  logic [DW-1:0]    m_axi_WDATA;
  logic             m_axi_BVALID, m_axi_BREADY;
  logic [1:0]       m_axi_BRESP;
  logic [IW-1:0]    m_axi_BID;
`ifdef WR_ARB_STATS_EN
  logic [NP*32-1:0] grant_cnt;
  logic [31:0]      fifo_full_cycles;
`endif

  axi_wr_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_AWVALID (s_axi_AWVALID),
    .s_axi_AWREADY (s_axi_AWREADY),
    .s_axi_AWADDR  (s_axi_AWADDR),
    .s_axi_AWLEN   (s_axi_AWLEN),
    .s_axi_WVALID  (s_axi_WVALID),
    .s_axi_WLAST   (s_axi_WLAST),
    .s_axi_WREADY  (s_axi_WREADY),
    .s_axi_WDATA   (s_axi_WDATA),
    .s_axi_BVALID  (s_axi_BVALID),
    .s_axi_BRESP   (s_axi_BRESP),
    .s_axi_BREADY  (s_axi_BREADY),
    .m_axi_AWVALID (m_axi_AWVALID),
    .m_axi_AWADDR  (m_axi_AWADDR),
    .m_axi_AWLEN   (m_axi_AWLEN),
    .m_axi_AWID    (m_axi_AWID),
    .m_axi_AWREADY (m_axi_AWREADY),
    .m_axi_WVALID  (m_axi_WVALID),
    .m_axi_WDATA   (m_axi_WDATA),
    .m_axi_WLAST   (m_axi_WLAST),
    .m_axi_WREADY  (m_axi_WREADY),
    .m_axi_BVALID  (m_axi_BVALID),
    .m_axi_BRESP   (m_axi_BRESP),
    .m_axi_BID     (m_axi_BID),
    .m_axi_BREADY  (m_axi_BREADY)
`ifdef WR_ARB_STATS_EN
    ,
    .grant_cnt        (grant_cnt),
    .fifo_full_cycles (fifo_full_cycles)
`endif
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } w_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  aw_t ae;
  w_t  we;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master-side monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axi_AWVALID && m_axi_AWREADY) begin
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          ae = aw_q.pop_front();
          check("aw_id", m_axi_AWID, ae.id);
          check("aw_addr", m_axi_AWADDR, ae.addr);
          check("aw_len", m_axi_AWLEN, ae.len);
        end
      end
      if (m_axi_WVALID && m_axi_WREADY) begin
        if (w_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          we = w_q.pop_front();
          check("w_data", m_axi_WDATA, we.data);
          check("w_last", m_axi_WLAST, we.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_aw(input int p, input logic [AW-1:0] a, input logic [7:0] l);
    aw_t t;
    t.id = IW'(p); t.addr = a; t.len = l;
    aw_q.push_back(t);
  endtask

  task automatic push_w(input logic [DW-1:0] d, input logic l);
    w_t t;
    t.data = d; t.last = l;
    w_q.push_back(t);
  endtask

  task automatic clear_inputs();
    s_axi_AWVALID = '0; s_axi_AWADDR = '0; s_axi_AWLEN = '0;
    s_axi_WVALID = '0; s_axi_WLAST = '0; s_axi_WDATA = '0; s_axi_BREADY = '0;
    m_axi_AWREADY = 1'b0; m_axi_WREADY = 1'b0;
    m_axi_BVALID = 1'b0; m_axi_BRESP = '0; m_axi_BID = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    aw_q.delete();
    w_q.delete();
  endtask

  logic [3:0]    oh;
  logic [AW-1:0] a0, a;

  initial begin
    rst = 1'b1;
    clear_inputs();
    s_axi_AWVALID = '1; s_axi_WVALID = '1; s_axi_WLAST = '1;
    m_axi_AWREADY = 1'b1; m_axi_WREADY = 1'b1;
    tick();
    tick();
    #1;
    check("rst_awready", s_axi_AWREADY, 0);
    check("rst_awvalid", m_axi_AWVALID, 0);
    check("rst_wvalid", m_axi_WVALID, 0);
    check("rst_wready", s_axi_WREADY, 0);
    do_reset();

    // Round-robin with all ports requesting, single-beat bursts.
    m_axi_AWREADY = 1'b1; m_axi_WREADY = 1'b1;
    for (int i = 0; i < NP; i++) begin
      s_axi_AWADDR[i*AW +: AW] = 33'h1_0000_0000 + AW'(i * 'h1000);
      s_axi_WDATA[i*DW +: DW]  = {8{32'hD000_0000 + 32'(i)}};
    end
    s_axi_WVALID = '1; s_axi_WLAST = '1;
    s_axi_AWVALID = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      oh = 4'b0001 << (k % 4);
      check("t1_awready", s_axi_AWREADY, oh);
      push_aw(k % 4, 33'h1_0000_0000 + AW'((k % 4) * 'h1000), 8'd0);
      push_w({8{32'hD000_0000 + 32'(k % 4)}}, 1'b1);
      tick();
      if (k == 7) s_axi_AWVALID = '0;
    end
    repeat (4) tick();
    check("t1_aw_drain", aw_q.size(), 0);
    check("t1_w_drain", w_q.size(), 0);
    do_reset();

    // W before AW is held off; port 2 burst of 4 beats.
    m_axi_AWREADY = 1'b1; m_axi_WREADY = 1'b1;
    s_axi_WVALID[1] = 1'b1; s_axi_WLAST[1] = 1'b1;
    s_axi_WDATA[1*DW +: DW] = 256'hBAD;
    #1;
    check("t2_early_wvalid", m_axi_WVALID, 0);
    check("t2_p1_wready_idle", s_axi_WREADY[1], 0);
    tick();
    s_axi_AWVALID[2] = 1'b1;
    s_axi_AWADDR[2*AW +: AW] = 33'h0_2000_0000;
    s_axi_AWLEN[2*8 +: 8] = 8'd3;
    push_aw(2, 33'h0_2000_0000, 8'd3);
    #1;
    check("t2_awready", s_axi_AWREADY, 4'b0100);
    tick();
    s_axi_AWVALID[2] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_axi_WVALID[2] = 1'b1;
      s_axi_WDATA[2*DW +: DW] = 256'hC0DE0 + 256'(b);
      s_axi_WLAST[2] = (b == 3);
      push_w(256'hC0DE0 + 256'(b), b == 3);
      #1;
      check("t2_p2_wready", s_axi_WREADY[2], 1);
      check("t2_p1_wready", s_axi_WREADY[1], 0);
      check("t2_wlast", m_axi_WLAST, b == 3);
      tick();
    end
    s_axi_WVALID[2] = 1'b0;
    #1;
    check("t2_wvalid_after", m_axi_WVALID, 0);
    check("t2_p1_wready_after", s_axi_WREADY[1], 0);
    tick();
    check("t2_aw_drain", aw_q.size(), 0);
    check("t2_w_drain", w_q.size(), 0);
    do_reset();

    // AW backpressure: register holds, then FIFO fills at 8 entries.
    a0 = 33'h0_0000_1000;
    s_axi_AWVALID[0] = 1'b1;
    s_axi_AWADDR[0 +: AW] = a0;
    push_aw(0, a0, 8'd0);
    #1;
    check("t3_first_grant", s_axi_AWREADY, 4'b0001);
    tick();
    for (int s = 1; s <= 10; s++) begin
      s_axi_AWADDR[0 +: AW] = a0 + AW'(s * 'h40);
      #1;
      check("t3_awvalid_hold", m_axi_AWVALID, 1);
      check("t3_awaddr_hold", m_axi_AWADDR, a0);
      check("t3_no_grant_stall", s_axi_AWREADY, 0);
      tick();
    end
    m_axi_AWREADY = 1'b1;
    for (int r = 0; r < 10; r++) begin
      a = 33'h0_0000_5000 + AW'(r * 'h40);
      s_axi_AWADDR[0 +: AW] = a;
      #1;
      if (r < 7) begin
        check("t3_refill_grant", s_axi_AWREADY, 4'b0001);
        push_aw(0, a, 8'd0);
      end else begin
        check("t3_full_no_grant", s_axi_AWREADY, 0);
      end
      if (r >= 8) check("t3_awvalid_drained", m_axi_AWVALID, 0);
      tick();
    end
    check("t3_aw_drain", aw_q.size(), 0);
    do_reset();

    // B routing.
    m_axi_BVALID = 1'b1; m_axi_BID = 5'd3; m_axi_BRESP = 2'b10;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t4_bvalid", s_axi_BVALID, 4'b1000);
      check("t4_bready_low", m_axi_BREADY, 0);
      check("t4_bresp", s_axi_BRESP[7:6], 2'b10);
      tick();
    end
    s_axi_BREADY[3] = 1'b1;
    #1;
    check("t4_bready_high", m_axi_BREADY, 1);
    check("t4_bvalid_held", s_axi_BVALID, 4'b1000);
    tick();
    m_axi_BID = 5'd7; s_axi_BREADY = '0;
    #1;
    check("t4_oob_bvalid", s_axi_BVALID, 0);
    check("t4_oob_bready", m_axi_BREADY, 1);
    tick();
    m_axi_BID = 5'd1; s_axi_BREADY = 4'b0010; m_axi_BRESP = 2'b01;
    #1;
    check("t4_id1_bvalid", s_axi_BVALID, 4'b0010);
    check("t4_id1_bready", m_axi_BREADY, 1);
    check("t4_bresp_bcast", s_axi_BRESP, 8'b0101_0101);
    tick();
    do_reset();

    // Reset during beat 2 of an 8-beat burst from port 1.
    m_axi_AWREADY = 1'b1; m_axi_WREADY = 1'b1;
    s_axi_AWVALID[1] = 1'b1;
    s_axi_AWADDR[1*AW +: AW] = 33'h0_0300_0000;
    s_axi_AWLEN[1*8 +: 8] = 8'd7;
    push_aw(1, 33'h0_0300_0000, 8'd7);
    #1;
    check("t5_awready", s_axi_AWREADY, 4'b0010);
    tick();
    s_axi_AWVALID[1] = 1'b0;
    s_axi_WVALID[1] = 1'b1;
    s_axi_WDATA[1*DW +: DW] = 256'hE0;
    push_w(256'hE0, 1'b0);
    #1;
    check("t5_beat1_valid", m_axi_WVALID, 1);
    tick();
    s_axi_WDATA[1*DW +: DW] = 256'hE1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_awvalid_cleared", m_axi_AWVALID, 0);
    check("t5_wvalid_cleared", m_axi_WVALID, 0);
    check("t5_wready_cleared", s_axi_WREADY, 0);
    check("t5_w_abandoned", w_q.size(), 0);
    check("t5_aw_done", aw_q.size(), 0);
    s_axi_WVALID = '0;
    tick();
    s_axi_AWVALID = 4'b0101;
    s_axi_AWADDR[0 +: AW] = 33'h0_0000_0A00;
    push_aw(0, 33'h0_0000_0A00, 8'd0);
    #1;
    check("t5_next_grant_p0", s_axi_AWREADY, 4'b0001);
    tick();
    s_axi_AWVALID = '0;
    tick();
    tick();
    check("t5_aw_drain", aw_q.size(), 0);

`ifdef WR_ARB_STATS_EN
    do_reset();
    m_axi_AWREADY = 1'b1; m_axi_WREADY = 1'b1;
    s_axi_AWADDR[1*AW +: AW] = 33'h0_0000_0B00;
    s_axi_WVALID[1] = 1'b1; s_axi_WLAST[1] = 1'b1;
    s_axi_WDATA[1*DW +: DW] = 256'h5;
    s_axi_AWVALID[1] = 1'b1;
    for (int g = 0; g < 5; g++) begin
      push_aw(1, 33'h0_0000_0B00, 8'd0);
      push_w(256'h5, 1'b1);
      tick();
    end
    s_axi_AWVALID = '0;
    tick();
    tick();
    check("t6_cnt_p0", grant_cnt[0 +: 32], 0);
    check("t6_cnt_p1", grant_cnt[32 +: 32], 5);
    check("t6_cnt_p2", grant_cnt[64 +: 32], 0);
    check("t6_cnt_p3", grant_cnt[96 +: 32], 0);
    check("t6_full_cycles", fifo_full_cycles, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
